// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between instruction fetch (IF) and load/store (D).
// One transaction outstanding at a time; D has priority, bounded by a starvation counter.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_gnt,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_valid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          fsm_state
);

    // Handshakes: a requester holds req and its fields until it sees gnt high in a cycle
    // (transfer at that rising edge); the memory side holds mem_req and mem_* frozen until
    // mem_ready is high in a cycle, and mem_rdata is taken in that same cycle.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [3:0] d_streak;
    logic       if_kill;
    logic       if_valid_q;
    logic       d_win;

    assign fsm_state = state;
    assign d_win     = d_req && (!if_req || (d_streak < LIMIT));

    // A flush arriving in the response cycle still cancels the pulse.
    assign if_valid  = if_valid_q && !if_flush;

    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (d_win) begin
                        d_gnt     = 1'b1;
                        state_nxt = D_BUSY;
                    end else if (if_req) begin
                        if_gnt    = 1'b1;
                        state_nxt = IF_BUSY;
                    end
                end
                IF_BUSY, D_BUSY: begin
                    if (mem_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            d_streak   <= '0;
            if_kill    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            if_valid_q <= 1'b0;
            d_valid    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_nxt;
            if_valid_q <= 1'b0;
            d_valid    <= 1'b0;

            if (d_gnt) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_be;
                // Only a win over a waiting IF counts towards starvation.
                if (if_req && d_streak != 4'hF) d_streak <= d_streak + 4'd1;
            end else if (if_gnt) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_be    <= '1;
                d_streak  <= '0;
                if_kill   <= if_flush;
            end

            if (state == IF_BUSY) begin
                if (mem_ready) begin
                    mem_req <= 1'b0;
                    if_kill <= 1'b0;
                    if (!if_kill && !if_flush) begin
                        if_valid_q <= 1'b1;
                        if_rdata   <= mem_rdata;
                    end
                end else if (if_flush) begin
                    if_kill <= 1'b1;
                end
            end

            if (state == D_BUSY && mem_ready) begin
                mem_req <= 1'b0;
                d_valid <= 1'b1;
                if (!mem_we) d_rdata <= mem_rdata;
            end
        end
    end

endmodule
